playlist_scheduler: RTL

- Controller that sequences the AutoPlay song player through a playlist of stored songs.
- Drives the player's song select and active-high reset.
- Handles start, stop, next and prev button pulses, and the player's end-of-song pulse.
- Inserts a programmable silent gap between songs.
- Sits between the debounced board buttons and the AutoPlay instance in the top level.

---
 rtl/playlist_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/playlist_scheduler.sv
// playlist_scheduler
//   Sequences the AutoPlay song player through a playlist. It holds the player
//   in reset between songs, presents the song index on selected_song, inserts
//   a GAP_CYCLES-long silent gap after each finished song, and reacts to the
//   start/stop/next/prev button pulses and the player's song_done pulse.
//
//   Optional feature macro: PLAYLIST_SHUFFLE_EN
//     When defined, it adds the input 'shuffle'. An 8-bit LFSR then picks the
//     song that follows a finished song (never the same song twice in a row).
//     With loop_mode=0, playback stops after NUM_SONGS songs have completed.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-low reset
//   start          pulse: begin playback at current index (IDLE only)
//   stop           pulse: abort playback, back to IDLE
//   next / prev    pulses: step index forward / backward with wrap
//   loop_mode      1 = wrap to song 0 after the last song, 0 = stop there
//   song_done      pulse from player: current song finished
//   shuffle        (PLAYLIST_SHUFFLE_EN only) randomised follow-on song
//   selected_song  song index presented to the player
//   player_rst     active-high player reset (1 = silent)
//   busy           1 whenever not IDLE
//   state_out      IDLE=0, LOAD=1, PLAY=2, GAP=3
module playlist_scheduler #(
    parameter int NUM_SONGS  = 8,
    parameter int SONG_W     = 4,
    parameter int GAP_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              next,
    input  logic              prev,
    input  logic              loop_mode,
    input  logic              song_done,
`ifdef PLAYLIST_SHUFFLE_EN
    input  logic              shuffle,
`endif
    output logic [SONG_W-1:0] selected_song,
    output logic              player_rst,
    output logic              busy,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2, GAP = 2'd3} state_t;

    localparam int                CNT_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [SONG_W-1:0] LAST     = SONG_W'(NUM_SONGS - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_t              state, state_nxt;
    logic [SONG_W-1:0]   idx, idx_nxt;
    logic [SONG_W-1:0]   sel_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;

    function automatic logic [SONG_W-1:0] idx_inc(input logic [SONG_W-1:0] i);
        return (i == LAST) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [SONG_W-1:0] idx_dec(input logic [SONG_W-1:0] i);
        return (i == '0) ? LAST : i - 1'b1;
    endfunction

`ifdef PLAYLIST_SHUFFLE_EN
    localparam int PLAY_W = $clog2(NUM_SONGS + 1);

    logic [7:0]        lfsr;
    logic [PLAY_W-1:0] played, played_nxt;
    logic [SONG_W-1:0] rnd_idx, shuf_idx;

    // Random pick, bumped by one when it would repeat the current song.
    assign rnd_idx  = SONG_W'(32'(lfsr) % NUM_SONGS);
    assign shuf_idx = (rnd_idx == idx) ? idx_inc(rnd_idx) : rnd_idx;

    // Free-running Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr   <= 8'hA5;
            played <= '0;
        end else begin
            lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            played <= played_nxt;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            selected_song <= '0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            cnt           <= cnt_nxt;
            selected_song <= sel_nxt;
        end
    end

    // Next-state logic. Priority inside PLAY/GAP: stop > next > prev > rest.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        sel_nxt   = selected_song;
`ifdef PLAYLIST_SHUFFLE_EN
        played_nxt = played;
`endif
        case (state)
            IDLE: begin
                if (next)      idx_nxt = idx_inc(idx);
                else if (prev) idx_nxt = idx_dec(idx);
                if (start) begin
                    state_nxt = LOAD;
`ifdef PLAYLIST_SHUFFLE_EN
                    played_nxt = '0;
`endif
                end
            end
            LOAD: begin
                sel_nxt   = idx;
                state_nxt = PLAY;
            end
            PLAY: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (next) begin
                    idx_nxt   = idx_inc(idx);
                    state_nxt = LOAD;
                end else if (prev) begin
                    idx_nxt   = idx_dec(idx);
                    state_nxt = LOAD;
                end else if (song_done) begin
`ifdef PLAYLIST_SHUFFLE_EN
                    played_nxt = played + 1'b1;
                    if (shuffle) begin
                        idx_nxt = shuf_idx;
                        if (!loop_mode && played_nxt == PLAY_W'(NUM_SONGS)) begin
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt   = GAP_LOAD;
                            state_nxt = GAP;
                        end
                    end else
`endif
                    begin
                        if (idx != LAST) begin
                            idx_nxt   = idx + 1'b1;
                            cnt_nxt   = GAP_LOAD;
                            state_nxt = GAP;
                        end else begin
                            idx_nxt = '0;
                            if (loop_mode) begin
                                cnt_nxt   = GAP_LOAD;
                                state_nxt = GAP;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (next) begin
                    idx_nxt   = idx_inc(idx);
                    state_nxt = LOAD;
                end else if (prev) begin
                    idx_nxt   = idx_dec(idx);
                    state_nxt = LOAD;
                end else if (cnt == '0) begin
                    state_nxt = LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from the state flops, so they follow reset
    // immediately and never depend on the inputs.
    always_comb begin
        player_rst = (state != PLAY);
        busy       = (state != IDLE);
        state_out  = state;
    end

endmodule
